// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per clock, divide-by-zero bypass.
// Define DIV_SIGNED_EN to add the div_signed port and two's-complement operation.
module div_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             div_signed,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] dvsr;

  logic             accept;
  logic [WIDTH:0]   sh;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             ovf;
  logic             fixup;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sgn;
`endif

  always_comb begin
    accept  = start && (state == IDLE || state == DONE);
    sh      = {rem, quo_sh[WIDTH-1]};
    qbit    = (sh >= {1'b0, dvsr});
    rem_nxt = qbit ? WIDTH'(sh - {1'b0, dvsr}) : sh[WIDTH-1:0];
    quo_nxt = {quo_sh[WIDTH-2:0], qbit};
`ifdef DIV_SIGNED_EN
    mag_a = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    ovf   = div_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    fixup = sgn;
`else
    mag_a = dividend;
    mag_b = divisor;
    ovf   = 1'b0;
    fixup = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo_sh    <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      sgn       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        rem <= '0;
        cnt <= '0;
        if (divisor == '0) begin
          // Zero divisor and signed overflow finish on the accept edge itself.
          quotient  <= '1;
          remainder <= dividend;
          state     <= DONE;
          done      <= 1'b1;
          busy      <= 1'b0;
        end else if (ovf) begin
          quotient  <= dividend;
          remainder <= '0;
          state     <= DONE;
          done      <= 1'b1;
          busy      <= 1'b0;
        end else begin
          quo_sh <= mag_a;
          dvsr   <= mag_b;
          state  <= RUN;
          busy   <= 1'b1;
`ifdef DIV_SIGNED_EN
          sgn    <= div_signed;
          neg_q  <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r  <= div_signed && dividend[WIDTH-1];
`endif
        end
      end else begin
        case (state)
          RUN: begin
            if (cnt == CW'(WIDTH)) begin
              // Extra cycle applies result signs after the magnitude loop.
`ifdef DIV_SIGNED_EN
              quotient  <= neg_q ? -quo_sh : quo_sh;
              remainder <= neg_r ? -rem : rem;
`endif
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              rem    <= rem_nxt;
              quo_sh <= quo_nxt;
              cnt    <= cnt + 1'b1;
              if (cnt == CW'(WIDTH - 1) && !fixup) begin
                quotient  <= quo_nxt;
                remainder <= rem_nxt;
                state     <= DONE;
                done      <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
